mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised memory arbiter. It shares the single byte-wide RAM/IO bus among NCH requester channels, such as instruction fetch, load/store unit and a future second LS port. It replaces the fixed two-port memory controller: round-robin arbitration, 1/2/4-byte little-endian transfers, and an optional per-channel read abort. It sits between the requesters and the `mem_din`/`mem_dout`/`mem_a`/`mem_wr` pins of the cpu top.

## Interface
- `NCH`, 2: number of requester channels (1..8); channel 0 is conventionally instruction fetch.
- `AW`, 32: address width; only bits 17:0 reach RAM, bits 17:16 == 2'b11 select I/O.
- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous, active-low reset.
- `rdy`  input  1  global ready; low freezes the block.
- `ch_req`  input  NCH  per-channel request level.
- `ch_we`  input  NCH  per-channel direction: 1 = write, 0 = read.
- `ch_addr`  input  NCH*AW  start addresses, channel i at [i*AW +: AW].
- `ch_len`  input  NCH*3  byte count per channel, 1..4; 0 or >4 is clamped to 4.
- `ch_wdata`  input  NCH*32  write data, byte 0 in [7:0].
- `ch_done`  output  NCH  one-cycle completion pulse.
- `ch_rdata`  output  32  read data of the completing channel, zero-extended; valid with `ch_done`.
- `busy`  output  1  high whenever the FSM is not IDLE.
- `mem_din`  input  8  RAM read byte.
- `mem_dout`  output  8  RAM write byte.
- `mem_a`  output  AW  RAM address.
- `mem_wr`  output  1  1 = write.
- `ch_flush`  input  NCH  per-channel read abort; present only with MEMARB_FLUSH_EN.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - If any `ch_req` bit is high, pick the first set bit scanning from `last+1` modulo NCH.
  - Latch that channel's addr, len, wdata and we.
  - Set `last` to the picked channel, clear byte index `k`, then go to READ or WRITE.
- READ:
  - In cycle j (j < len), drive `mem_a = addr + j` with `mem_wr = 0`.
  - In cycle j (j >= 1), capture `mem_din` into `rdata[8*(j-1) +: 8]`.
  - READ lasts len+1 cycles, then the FSM goes to DONE.
  - Exactly len addresses are issued, with no speculative extra byte. This is required for the I/O port at 0x30000, which consumes one byte per read.
- WRITE:
  - In cycle j (j < len), drive `mem_a = addr + j`, `mem_wr = 1` and `mem_dout = wdata[8j +: 8]`.
  - WRITE lasts len cycles, then the FSM goes to DONE.
- DONE:
  - Pulse `ch_done[granted]` and drive `ch_rdata` (0 for writes), then go to IDLE.
  - The bus is idle during DONE.
- Requester rule:
  - Hold `ch_req` and all channel inputs stable until `ch_done`.
  - Drop `ch_req` in the cycle after `ch_done`.
  - `ch_req` high in IDLE is always treated as a new request.
- Address arithmetic is modulo 2^AW; a transfer crossing 0x1FFFF simply increments.
- Idle bus values: `mem_a = 0`, `mem_wr = 0`, `mem_dout = 0`.

## Timing
- Reset (`rst` low, asynchronous): FSM to IDLE, `last = NCH-1`, `k = 0`.
  - All outputs go to 0: `ch_done`, `ch_rdata`, `busy`, `mem_a`, `mem_wr`, `mem_dout`.
  - Reset mid-transfer abandons the transfer with no `ch_done`.
- Latency from `ch_req` seen in IDLE to `ch_done`: read len+2 cycles, write len+1 cycles.
- Back-to-back: the next grant happens in the IDLE cycle after DONE, so the minimum request spacing is one idle bus cycle.
- `rdy` low:
  - No state, index or capture register changes.
  - `mem_a` and `mem_dout` hold their values; `mem_wr` is forced to 0.
  - When `rdy` returns, the held byte is reissued. A read capture in that cycle sees data for the held address.
- A request arriving while not IDLE waits; simultaneous requests are resolved by round-robin order only.

## Configuration
- `MEMARB_FLUSH_EN` defined:
  - Adds the `ch_flush` port.
  - In READ, `ch_flush[granted] = 1` aborts the transfer: next state is IDLE with no `ch_done`.
  - In IDLE, requests whose flush bit is set are masked for that cycle.
  - WRITE is never aborted, so I/O side effects are preserved.
- Undefined: no port, and every transfer runs to completion.

## Test plan
- NCH=2, channel 1 reads len 4 at 0x100 with RAM bytes 11,22,33,44:
  - `mem_a` is 0x100..0x103 over 4 cycles.
  - `ch_done[1]` fires 6 cycles after the grant cycle, with `ch_rdata = 0x44332211`.
- Channel 0 writes len 2 at 0x2000 with `wdata = 0xBEEF`:
  - `mem_wr = 1` for exactly 2 cycles, with `mem_dout` EF then BE.
  - `ch_done[0]` fires in the next cycle and `ch_rdata = 0`.
- NCH=3, all three channels request continuously with len 1:
  - Grant order is 0,1,2,0,1,2.
  - No channel is granted twice before each other requesting channel has been granted once.
- Pull `rdy` low for 3 cycles during byte 2 of a len-4 write:
  - `mem_wr` is 0 while `rdy` is low and `mem_a` holds.
  - Byte 2 is written exactly once after resume, and done is delayed by 3 cycles.
- With MEMARB_FLUSH_EN, flush channel 0 during cycle 2 of a len-4 read:
  - No `ch_done[0]`; the FSM is in IDLE next cycle.
  - A pending channel-1 request is then granted.
- Assert `rst` low mid-read:
  - All outputs are 0 immediately; the first grant after release goes to channel 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide RAM/IO bus among NCH requesters.
// Define MEMARB_FLUSH_EN to add the per-channel read abort port ch_flush.
module mem_arbiter #(
  parameter int NCH = 2,
  parameter int AW  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_we,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*3-1:0]  ch_len,
  input  logic [NCH*32-1:0] ch_wdata,
`ifdef MEMARB_FLUSH_EN
  input  logic [NCH-1:0]    ch_flush,
`endif
  output logic [NCH-1:0]    ch_done,
  output logic [31:0]       ch_rdata,
  output logic              busy,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [AW-1:0]     mem_a,
  output logic              mem_wr
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} ArbState;

  ArbState       state, stateNext;
  logic [IW-1:0] last, lastNext;
  logic [2:0]    k, kNext;
  logic [AW-1:0] addrReg, addrNext;
  logic [2:0]    lenReg, lenNext;
  logic [31:0]   wdataReg, wdataNext;
  logic [31:0]   rdataReg, rdataNext;
  logic          weReg, weNext;

  logic [NCH-1:0] reqMasked;
  logic           flushGranted;
  logic           pickFound;
  logic [IW-1:0]  pickIdx;
  logic [AW-1:0]  pickAddr;
  logic [2:0]     pickLen;
  logic [2:0]     lenClamped;
  logic [31:0]    pickWdata;
  logic           pickWe;

  // The granted channel is always the one recorded in last.
`ifdef MEMARB_FLUSH_EN
  assign reqMasked    = ch_req & ~ch_flush;
  assign flushGranted = ch_flush[last];
`else
  assign reqMasked    = ch_req;
  assign flushGranted = 1'b0;
`endif

  // Round-robin scan starting just after the previously granted channel.
  always_comb begin
    int cand;
    cand      = 0;
    pickFound = 1'b0;
    pickIdx   = '0;
    for (int off = 1; off <= NCH; off++) begin
      cand = int'(last) + off;
      if (cand >= NCH) cand = cand - NCH;
      if (!pickFound && reqMasked[cand]) begin
        pickFound = 1'b1;
        pickIdx   = IW'(cand);
      end
    end
  end

  always_comb begin
    pickAddr  = '0;
    pickLen   = '0;
    pickWdata = '0;
    pickWe    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (pickIdx == IW'(i)) begin
        pickAddr  = ch_addr[i*AW +: AW];
        pickLen   = ch_len[i*3 +: 3];
        pickWdata = ch_wdata[i*32 +: 32];
        pickWe    = ch_we[i];
      end
    end
  end

  assign lenClamped = (pickLen == 3'd0 || pickLen > 3'd4) ? 3'd4 : pickLen;

  // Read data trails the address by one cycle, so READ has one extra capture cycle.
  always_comb begin
    stateNext = state;
    lastNext  = last;
    kNext     = k;
    addrNext  = addrReg;
    lenNext   = lenReg;
    wdataNext = wdataReg;
    weNext    = weReg;
    rdataNext = rdataReg;
    if (rdy) begin
      case (state)
        IDLE: begin
          if (pickFound) begin
            lastNext  = pickIdx;
            kNext     = 3'd0;
            addrNext  = pickAddr;
            lenNext   = lenClamped;
            wdataNext = pickWdata;
            weNext    = pickWe;
            rdataNext = '0;
            stateNext = pickWe ? WRITE : READ;
          end
        end
        READ: begin
          if (flushGranted) begin
            stateNext = IDLE;
          end else begin
            case (k)
              3'd1:    rdataNext[7:0]   = mem_din;
              3'd2:    rdataNext[15:8]  = mem_din;
              3'd3:    rdataNext[23:16] = mem_din;
              3'd4:    rdataNext[31:24] = mem_din;
              default: ;
            endcase
            if (k == lenReg) stateNext = DONE;
            else             kNext     = k + 3'd1;
          end
        end
        WRITE: begin
          if (k == lenReg - 3'd1) stateNext = DONE;
          else                    kNext     = k + 3'd1;
        end
        DONE:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Bus outputs derive from held registers, so a stall keeps address and data steady.
  always_comb begin
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = '0;
    ch_done  = '0;
    ch_rdata = '0;
    busy     = (state != IDLE);
    case (state)
      READ: begin
        if (k < lenReg) mem_a = addrReg + AW'(k);
      end
      WRITE: begin
        mem_a  = addrReg + AW'(k);
        mem_wr = rdy;
        case (k)
          3'd0:    mem_dout = wdataReg[7:0];
          3'd1:    mem_dout = wdataReg[15:8];
          3'd2:    mem_dout = wdataReg[23:16];
          default: mem_dout = wdataReg[31:24];
        endcase
      end
      DONE: begin
        for (int i = 0; i < NCH; i++) ch_done[i] = rdy && (last == IW'(i));
        ch_rdata = weReg ? 32'd0 : rdataReg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last     <= IW'(NCH - 1);
      k        <= '0;
      addrReg  <= '0;
      lenReg   <= '0;
      wdataReg <= '0;
      rdataReg <= '0;
      weReg    <= 1'b0;
    end else begin
      state    <= stateNext;
      last     <= lastNext;
      k        <= kNext;
      addrReg  <= addrNext;
      lenReg   <= lenNext;
      wdataReg <= wdataNext;
      rdataReg <= rdataNext;
      weReg    <= weNext;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised self-checking bench for mem_arbiter (NCH=3) with a byte RAM model
// and a transaction-level reference model of arbitration, latency and data.
module tb_mem_arbiter;

  localparam int NCH = 3;
  localparam int AW  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic [NCH-1:0]    ch_req;
  logic [NCH-1:0]    ch_we;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*3-1:0]  ch_len;
  logic [NCH*32-1:0] ch_wdata;
`ifdef MEMARB_FLUSH_EN
  logic [NCH-1:0]    ch_flush;
`endif
  logic [NCH-1:0]    ch_done;
  logic [31:0]       ch_rdata;
  logic              busy;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [AW-1:0]     mem_a;
  logic              mem_wr;

  int compared   = 0;
  int mismatched = 0;
  int modelLast;

  logic [7:0]  seedRam    [0:65535];
  logic [7:0]  ram        [0:65535];
  logic        ramWritten [0:65535];
  logic [7:0]  refRam     [0:65535];
  int          wrCount    = 0;
  int          watchCount = 0;
  logic [31:0] watchAddr  = 32'hFFFF_FFFF;

  logic [31:0] traceA    [0:63];
  logic        traceWr   [0:63];
  logic [7:0]  traceDout [0:63];

  mem_arbiter #(.NCH(NCH), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .ch_req   (ch_req),
    .ch_we    (ch_we),
    .ch_addr  (ch_addr),
    .ch_len   (ch_len),
    .ch_wdata (ch_wdata),
`ifdef MEMARB_FLUSH_EN
    .ch_flush (ch_flush),
`endif
    .ch_done  (ch_done),
    .ch_rdata (ch_rdata),
    .busy     (busy),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .mem_a    (mem_a),
    .mem_wr   (mem_wr)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: one-cycle read latency, unwritten bytes come from the seed image.
  always @(posedge clk) begin
    mem_din <= ramWritten[mem_a[15:0]] ? ram[mem_a[15:0]] : seedRam[mem_a[15:0]];
    if (mem_wr) begin
      ram[mem_a[15:0]]        <= mem_dout;
      ramWritten[mem_a[15:0]] <= 1'b1;
      wrCount                 <= wrCount + 1;
      if (mem_a == watchAddr) watchCount <= watchCount + 1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired compared=%0d", compared);
    $fatal(1, "[TB] watchdog");
  end

  // Requests one transfer in the next cycle and records the bus until ch_done.
  task automatic driveTransfer(input int ch, input logic we, input logic [31:0] addr,
                               input logic [2:0] len, input logic [31:0] wdata,
                               output int doneCyc, output logic [NCH-1:0] doneVec,
                               output logic [31:0] rdata);
    @(negedge clk);
    ch_we[ch]              = we;
    ch_addr[ch*AW +: AW]   = addr;
    ch_len[ch*3 +: 3]      = len;
    ch_wdata[ch*32 +: 32]  = wdata;
    ch_req[ch]             = 1'b1;
    doneCyc = -1;
    doneVec = '0;
    rdata   = '0;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      traceA[c]    = mem_a;
      traceWr[c]   = mem_wr;
      traceDout[c] = mem_dout;
      if (ch_done != '0) begin
        doneCyc = c;
        doneVec = ch_done;
        rdata   = ch_rdata;
        break;
      end
    end
    ch_req[ch] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (ch_done !== '0) begin mismatched++; $display("[TB] FAIL reset_done got=%0h want=0", ch_done); end
    compared++; if (ch_rdata !== '0) begin mismatched++; $display("[TB] FAIL reset_rdata got=%0h want=0", ch_rdata); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got=%0b want=0", busy); end
    compared++; if (mem_a !== '0) begin mismatched++; $display("[TB] FAIL reset_mem_a got=%0h want=0", mem_a); end
    compared++; if (mem_wr !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_wr got=%0b want=0", mem_wr); end
    compared++; if (mem_dout !== '0) begin mismatched++; $display("[TB] FAIL reset_mem_dout got=%0h want=0", mem_dout); end
    rst = 1'b1;
    @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_after_reset busy got=%0b want=0", busy); end
    modelLast = NCH - 1;
  endtask

  // All requesters in a mask hold ch_req; each grant must follow the rotating scan.
  task automatic test_round_robin;
    logic [NCH-1:0] mask;
    logic [NCH-1:0] expVec;
    int grants;
    int expCh;
    int cand;
    for (int burst = 0; burst < 4; burst++) begin
      mask = (burst == 0) ? {NCH{1'b1}} : NCH'($urandom_range(1, (1 << NCH) - 1));
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        ch_we[i]            = 1'b0;
        ch_len[i*3 +: 3]    = 3'd1;
        ch_addr[i*AW +: AW] = $urandom;
      end
      ch_req = mask;
      grants = 0;
      for (int c = 0; c < 200 && grants < 6; c++) begin
        @(negedge clk);
        if (ch_done != '0) begin
          expCh = -1;
          for (int off = 1; off <= NCH; off++) begin
            cand = (modelLast + off) % NCH;
            if (expCh < 0 && mask[cand]) expCh = cand;
          end
          expVec = '0;
          expVec[expCh] = 1'b1;
          compared++;
          if (ch_done !== expVec) begin
            mismatched++;
            $display("[TB] FAIL rr_grant mask=%b got=%b want=%b", mask, ch_done, expVec);
          end
          modelLast = expCh;
          grants++;
        end
      end
      ch_req = '0;
      compared++;
      if (grants != 6) begin mismatched++; $display("[TB] FAIL rr_timeout grants got=%0d want=6", grants); end
      @(negedge clk);
    end
  endtask

  task automatic test_read_basic;
    int doneCyc;
    logic [NCH-1:0] doneVec;
    logic [31:0] rdata;
    driveTransfer(1, 1'b0, 32'h100, 3'd4, 32'h0, doneCyc, doneVec, rdata);
    compared++; if (doneCyc != 6) begin mismatched++; $display("[TB] FAIL read_latency got=%0d want=6", doneCyc); end
    compared++; if (doneVec !== 3'b010) begin mismatched++; $display("[TB] FAIL read_done_vec got=%b want=010", doneVec); end
    compared++; if (rdata !== 32'h44332211) begin mismatched++; $display("[TB] FAIL read_data got=%h want=44332211", rdata); end
    for (int c = 1; c <= 4; c++) begin
      compared++;
      if (traceA[c] !== 32'h100 + 32'(c - 1) || traceWr[c] !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL read_addr cyc=%0d got=%h/%0b want=%h/0", c, traceA[c], traceWr[c], 32'h100 + 32'(c - 1));
      end
    end
    compared++; if (traceA[5] !== '0) begin mismatched++; $display("[TB] FAIL read_no_extra got=%h want=0", traceA[5]); end
    modelLast = 1;
  endtask

  task automatic test_write_basic;
    int doneCyc;
    int startWr;
    logic [NCH-1:0] doneVec;
    logic [31:0] rdata;
    startWr = wrCount;
    driveTransfer(0, 1'b1, 32'h2000, 3'd2, 32'h0000BEEF, doneCyc, doneVec, rdata);
    refRam[16'h2000] = 8'hEF;
    refRam[16'h2001] = 8'hBE;
    compared++; if (doneCyc != 3) begin mismatched++; $display("[TB] FAIL write_latency got=%0d want=3", doneCyc); end
    compared++; if (doneVec !== 3'b001) begin mismatched++; $display("[TB] FAIL write_done_vec got=%b want=001", doneVec); end
    compared++; if (rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL write_rdata got=%h want=0", rdata); end
    compared++;
    if (traceA[1] !== 32'h2000 || traceWr[1] !== 1'b1 || traceDout[1] !== 8'hEF) begin
      mismatched++; $display("[TB] FAIL write_byte0 got=%h/%0b/%h want=2000/1/ef", traceA[1], traceWr[1], traceDout[1]);
    end
    compared++;
    if (traceA[2] !== 32'h2001 || traceWr[2] !== 1'b1 || traceDout[2] !== 8'hBE) begin
      mismatched++; $display("[TB] FAIL write_byte1 got=%h/%0b/%h want=2001/1/be", traceA[2], traceWr[2], traceDout[2]);
    end
    compared++; if (wrCount - startWr != 2) begin mismatched++; $display("[TB] FAIL write_count got=%0d want=2", wrCount - startWr); end
    modelLast = 0;
  endtask

  task automatic test_rdy_stall;
    int c;
    int doneCyc;
    int startWr;
    int startWatch;
    logic [31:0] wdata;
    wdata = $urandom;
    @(negedge clk);
    ch_we[0]          = 1'b1;
    ch_addr[0 +: AW]  = 32'h3000;
    ch_len[0 +: 3]    = 3'd4;
    ch_wdata[0 +: 32] = wdata;
    ch_req[0]         = 1'b1;
    watchAddr  = 32'h3002;
    startWr    = wrCount;
    startWatch = watchCount;
    repeat (3) @(negedge clk);
    compared++;
    if (mem_a !== 32'h3002 || mem_wr !== 1'b1) begin
      mismatched++; $display("[TB] FAIL stall_pre got=%h/%0b want=3002/1", mem_a, mem_wr);
    end
    rdy = 1'b0;
    #1;
    compared++;
    if (mem_a !== 32'h3002 || mem_wr !== 1'b0) begin
      mismatched++; $display("[TB] FAIL stall_enter got=%h/%0b want=3002/0", mem_a, mem_wr);
    end
    for (c = 4; c <= 6; c++) begin
      @(negedge clk);
      compared++;
      if (mem_a !== 32'h3002 || mem_wr !== 1'b0 || mem_dout !== wdata[23:16]) begin
        mismatched++; $display("[TB] FAIL stall_hold cyc=%0d got=%h/%0b/%h want=3002/0/%h", c, mem_a, mem_wr, mem_dout, wdata[23:16]);
      end
    end
    rdy = 1'b1;
    #1;
    compared++;
    if (mem_a !== 32'h3002 || mem_wr !== 1'b1) begin
      mismatched++; $display("[TB] FAIL stall_reissue got=%h/%0b want=3002/1", mem_a, mem_wr);
    end
    doneCyc = -1;
    for (c = 7; c < 30; c++) begin
      @(negedge clk);
      if (ch_done != '0) begin doneCyc = c; break; end
    end
    ch_req[0] = 1'b0;
    for (int j = 0; j < 4; j++) refRam[16'h3000 + 16'(j)] = wdata[8*j +: 8];
    compared++; if (doneCyc != 8) begin mismatched++; $display("[TB] FAIL stall_latency got=%0d want=8", doneCyc); end
    compared++; if (wrCount - startWr != 4) begin mismatched++; $display("[TB] FAIL stall_wr_count got=%0d want=4", wrCount - startWr); end
    compared++; if (watchCount - startWatch != 1) begin mismatched++; $display("[TB] FAIL stall_byte2_once got=%0d want=1", watchCount - startWatch); end
    compared++;
    if ({ram[16'h3003], ram[16'h3002], ram[16'h3001], ram[16'h3000]} !== wdata) begin
      mismatched++; $display("[TB] FAIL stall_ram got=%h want=%h", {ram[16'h3003], ram[16'h3002], ram[16'h3001], ram[16'h3000]}, wdata);
    end
    watchAddr = 32'hFFFF_FFFF;
    modelLast = 0;
  endtask

  // Random single transfers, including clamped lengths and a 0x1FFFF crossing.
  task automatic test_random;
    int ch;
    logic we;
    logic [31:0] addr;
    logic [2:0] len;
    int L;
    logic [31:0] wdata;
    logic [31:0] expData;
    int expLat;
    int doneCyc;
    int startWr;
    logic [NCH-1:0] doneVec;
    logic [NCH-1:0] expVec;
    logic [31:0] rdata;
    logic busOk;
    for (int n = 0; n < 40; n++) begin
      ch    = $urandom_range(0, NCH - 1);
      we    = 1'($urandom_range(0, 1));
      addr  = ($urandom_range(0, 3) == 0) ? 32'h0001_FFFE : $urandom;
      len   = 3'($urandom_range(0, 7));
      wdata = $urandom;
      L     = (len == 3'd0 || len > 3'd4) ? 4 : int'(len);
      expData = '0;
      for (int j = 0; j < L; j++) begin
        if (we) refRam[16'(addr + 32'(j))] = wdata[8*j +: 8];
        else    expData[8*j +: 8] = refRam[16'(addr + 32'(j))];
      end
      expLat = we ? L + 1 : L + 2;
      expVec = '0;
      expVec[ch] = 1'b1;
      startWr = wrCount;
      driveTransfer(ch, we, addr, len, wdata, doneCyc, doneVec, rdata);
      busOk = (doneCyc > 0);
      if (busOk) begin
        for (int j = 0; j < L; j++) begin
          if (traceA[j+1] !== addr + 32'(j) || traceWr[j+1] !== we) busOk = 1'b0;
          if (we && traceDout[j+1] !== wdata[8*j +: 8]) busOk = 1'b0;
        end
        if (traceA[L+1] !== '0 || traceWr[L+1] !== 1'b0) busOk = 1'b0;
      end
      compared++; if (doneCyc != expLat) begin mismatched++; $display("[TB] FAIL rand_latency n=%0d we=%0b len=%0d got=%0d want=%0d", n, we, len, doneCyc, expLat); end
      compared++; if (doneVec !== expVec) begin mismatched++; $display("[TB] FAIL rand_done_vec n=%0d got=%b want=%b", n, doneVec, expVec); end
      compared++; if (rdata !== expData) begin mismatched++; $display("[TB] FAIL rand_rdata n=%0d addr=%h got=%h want=%h", n, addr, rdata, expData); end
      compared++; if (busOk !== 1'b1) begin mismatched++; $display("[TB] FAIL rand_bus n=%0d addr=%h we=%0b len=%0d got=0 want=1", n, addr, we, len); end
      compared++; if (wrCount - startWr != (we ? L : 0)) begin mismatched++; $display("[TB] FAIL rand_wr_count n=%0d got=%0d want=%0d", n, wrCount - startWr, we ? L : 0); end
      modelLast = ch;
    end
  endtask

  task automatic test_reset_mid_read;
    int doneCyc;
    @(negedge clk);
    ch_we[2]          = 1'b0;
    ch_addr[2*AW +: AW] = 32'h600;
    ch_len[2*3 +: 3]  = 3'd4;
    ch_req[2]         = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    compared++; if (ch_done !== '0) begin mismatched++; $display("[TB] FAIL midrst_done got=%b want=0", ch_done); end
    compared++; if (ch_rdata !== '0) begin mismatched++; $display("[TB] FAIL midrst_rdata got=%h want=0", ch_rdata); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy got=%0b want=0", busy); end
    compared++; if (mem_a !== '0) begin mismatched++; $display("[TB] FAIL midrst_mem_a got=%h want=0", mem_a); end
    compared++; if (mem_wr !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_mem_wr got=%0b want=0", mem_wr); end
    compared++; if (mem_dout !== '0) begin mismatched++; $display("[TB] FAIL midrst_mem_dout got=%h want=0", mem_dout); end
    ch_req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ch_we  = '0;
    ch_len = {NCH{3'd1}};
    ch_req = {NCH{1'b1}};
    doneCyc = -1;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (ch_done != '0) begin
        doneCyc = c;
        compared++;
        if (ch_done !== 3'b001) begin mismatched++; $display("[TB] FAIL midrst_first_grant got=%b want=001", ch_done); end
        break;
      end
    end
    ch_req = '0;
    compared++; if (doneCyc != 3) begin mismatched++; $display("[TB] FAIL midrst_latency got=%0d want=3", doneCyc); end
    modelLast = 0;
  endtask

`ifdef MEMARB_FLUSH_EN
  task automatic test_flush;
    int doneCyc;
    logic sawDone0;
    @(negedge clk);
    ch_we[0]            = 1'b0;
    ch_addr[0 +: AW]    = 32'h400;
    ch_len[0 +: 3]      = 3'd4;
    ch_req[0]           = 1'b1;
    sawDone0 = 1'b0;
    @(negedge clk);
    ch_we[1]            = 1'b0;
    ch_addr[AW +: AW]   = 32'h500;
    ch_len[3 +: 3]      = 3'd1;
    ch_req[1]           = 1'b1;
    @(negedge clk);
    ch_flush[0] = 1'b1;
    @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_idle busy got=%0b want=0", busy); end
    if (ch_done[0]) sawDone0 = 1'b1;
    ch_flush[0] = 1'b0;
    ch_req[0]   = 1'b0;
    doneCyc = -1;
    for (int c = 4; c < 30; c++) begin
      @(negedge clk);
      if (ch_done[0]) sawDone0 = 1'b1;
      if (ch_done != '0) begin
        doneCyc = c;
        compared++;
        if (ch_done !== 3'b010 || ch_rdata !== {24'd0, refRam[16'h500]}) begin
          mismatched++; $display("[TB] FAIL flush_next_grant got=%b/%h want=010/%h", ch_done, ch_rdata, {24'd0, refRam[16'h500]});
        end
        break;
      end
    end
    ch_req[1] = 1'b0;
    compared++; if (doneCyc != 6) begin mismatched++; $display("[TB] FAIL flush_latency got=%0d want=6", doneCyc); end
    compared++; if (sawDone0 !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_no_done got=1 want=0"); end
    modelLast = 1;
  endtask
`endif

  initial begin
    rst      = 1'b0;
    rdy      = 1'b1;
    ch_req   = '0;
    ch_we    = '0;
    ch_addr  = '0;
    ch_len   = '0;
    ch_wdata = '0;
`ifdef MEMARB_FLUSH_EN
    ch_flush = '0;
`endif
    for (int a = 0; a < 65536; a++) begin
      seedRam[a]    = 8'($urandom);
      ramWritten[a] = 1'b0;
    end
    seedRam[16'h100] = 8'h11;
    seedRam[16'h101] = 8'h22;
    seedRam[16'h102] = 8'h33;
    seedRam[16'h103] = 8'h44;
    for (int a = 0; a < 65536; a++) refRam[a] = seedRam[a];

    test_reset();
    test_round_robin();
    test_read_basic();
    test_write_basic();
    test_rdy_stall();
    test_random();
    test_reset_mid_read();
`ifdef MEMARB_FLUSH_EN
    test_flush();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
